// File: rtl/clk_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_tick_gen
// Summary  : Multi-channel programmable clock divider producing one-cycle
//            tick pulses and 50% square waves. Optional macro
//            CLK_TICK_GEN_CASCADE_EN chains each channel onto the previous
//            channel's terminal event.
// Revision : 1.0 - initial release
// ============================================================================
module clk_tick_gen #(
  parameter int                NCH      = 3,
  parameter int                CW       = 32,
  parameter logic [NCH*CW-1:0] DIV_INIT = {NCH{32'd50_000_000}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           ld,
  input  logic [2:0]     ld_ch,
  input  logic [CW-1:0]  ld_div,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq
);

  logic [CW-1:0]  r_div [NCH];
  logic [CW-1:0]  r_cnt [NCH];
  logic [NCH-1:0] r_tick;
  logic [NCH-1:0] r_sq;

  logic [NCH-1:0] w_adv;
  logic [NCH-1:0] w_ld;
  logic [NCH-1:0] w_tc;
`ifdef CLK_TICK_GEN_CASCADE_EN
  logic           w_carry;
`endif

  // Terminal events already exclude a same-edge load, so a loaded channel
  // neither ticks nor advances the channel chained after it.
  always_comb begin
    w_adv = '0;
    w_ld  = '0;
    w_tc  = '0;
`ifdef CLK_TICK_GEN_CASCADE_EN
    w_carry = 1'b1;
`endif
    for (int i = 0; i < NCH; i++) begin
`ifdef CLK_TICK_GEN_CASCADE_EN
      w_adv[i] = w_carry;
`else
      w_adv[i] = 1'b1;
`endif
      w_ld[i] = ld && (ld_ch == 3'(i));
      w_tc[i] = en && w_adv[i] && (r_div[i] != '0) &&
                (r_cnt[i] == r_div[i] - CW'(1)) && !w_ld[i];
`ifdef CLK_TICK_GEN_CASCADE_EN
      w_carry = w_tc[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        r_div[i]  <= DIV_INIT[i*CW +: CW];
        r_cnt[i]  <= '0;
        r_tick[i] <= 1'b0;
        r_sq[i]   <= 1'b0;
      end else if (w_ld[i]) begin
        r_div[i]  <= ld_div;
        r_cnt[i]  <= '0;
        r_tick[i] <= 1'b0;
      end else if (w_tc[i]) begin
        r_cnt[i]  <= '0;
        r_tick[i] <= 1'b1;
        r_sq[i]   <= ~r_sq[i];
      end else begin
        r_tick[i] <= 1'b0;
        if (en && w_adv[i] && (r_div[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign tick = r_tick;
  assign sq   = r_sq;

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_tick_gen
// Summary  : Self-checking bench for clk_tick_gen (NCH=3, CW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_tick_gen;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic           ld  = 1'b0;
  logic [2:0]     ld_ch  = 3'd0;
  logic [CW-1:0]  ld_div = '0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;

  clk_tick_gen #(
    .NCH      (NCH),
    .CW       (CW),
    .DIV_INIT ({8'd0, 8'd1, 8'd4})
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ld     (ld),
    .ld_ch  (ld_ch),
    .ld_div (ld_div),
    .tick   (tick),
    .sq     (sq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [2:0] ch;
    logic [7:0] dv;
    logic [2:0] et;
    logic [2:0] es;
    logic [2:0] m;
  } vec_t;

  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic l,
                              input logic [2:0] c, input logic [7:0] d,
                              input logic [2:0] et, input logic [2:0] es,
                              input logic [2:0] m);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.ch = c; v.dv = d;
    v.et = et; v.es = es; v.m = m;
    return v;
  endfunction

  task automatic check(input string name);
    vec_t e;
    n_tests += 2;
    if (sb.size() == 0) begin
      n_fail += 2;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (((tick ^ e.et) & e.m) != 3'b000) begin
        n_fail++;
        $display("FAIL %s tick: got %b want %b (mask %b)", name, tick, e.et, e.m);
      end
      if (((sq ^ e.es) & e.m) != 3'b000) begin
        n_fail++;
        $display("FAIL %s sq: got %b want %b (mask %b)", name, sq, e.es, e.m);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; en = v.en; ld = v.ld; ld_ch = v.ch; ld_div = v.dv;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifndef CLK_TICK_GEN_CASCADE_EN
    vec_t tbl[30];
    // Divisors out of reset: ch0=4, ch1=1, ch2=0 (disabled).
    tbl[0]  = mk(1,0,0,3'd0,8'd0, 3'b000,3'b000,3'b111);
    tbl[1]  = mk(1,0,0,3'd0,8'd0, 3'b000,3'b000,3'b111);
    tbl[2]  = mk(0,1,0,3'd0,8'd0, 3'b010,3'b010,3'b111);
    tbl[3]  = mk(0,1,0,3'd0,8'd0, 3'b010,3'b000,3'b111);
    tbl[4]  = mk(0,1,0,3'd0,8'd0, 3'b010,3'b010,3'b111);
    tbl[5]  = mk(0,1,0,3'd0,8'd0, 3'b011,3'b001,3'b111);
    tbl[6]  = mk(0,1,0,3'd0,8'd0, 3'b010,3'b011,3'b111);
    tbl[7]  = mk(0,1,0,3'd0,8'd0, 3'b010,3'b001,3'b111);
    tbl[8]  = mk(0,1,0,3'd0,8'd0, 3'b010,3'b011,3'b111);
    tbl[9]  = mk(0,1,0,3'd0,8'd0, 3'b011,3'b000,3'b111);
    tbl[10] = mk(0,0,0,3'd0,8'd0, 3'b000,3'b000,3'b111);
    tbl[11] = mk(0,0,0,3'd0,8'd0, 3'b000,3'b000,3'b111);
    tbl[12] = mk(0,1,0,3'd0,8'd0, 3'b010,3'b010,3'b111);
    tbl[13] = mk(0,1,1,3'd5,8'd9, 3'b010,3'b000,3'b111);
    tbl[14] = mk(0,1,0,3'd0,8'd0, 3'b010,3'b010,3'b111);
    tbl[15] = mk(0,1,1,3'd1,8'd2, 3'b001,3'b011,3'b111);
    tbl[16] = mk(0,1,0,3'd0,8'd0, 3'b000,3'b011,3'b111);
    tbl[17] = mk(0,1,0,3'd0,8'd0, 3'b010,3'b001,3'b111);
    tbl[18] = mk(0,1,0,3'd0,8'd0, 3'b000,3'b001,3'b111);
    tbl[19] = mk(0,1,0,3'd0,8'd0, 3'b011,3'b010,3'b111);
    tbl[20] = mk(0,1,1,3'd2,8'd1, 3'b000,3'b010,3'b111);
    tbl[21] = mk(0,1,0,3'd0,8'd0, 3'b110,3'b100,3'b111);
    tbl[22] = mk(0,1,0,3'd0,8'd0, 3'b100,3'b000,3'b111);
    tbl[23] = mk(0,1,1,3'd0,8'd0, 3'b110,3'b110,3'b111);
    tbl[24] = mk(0,1,0,3'd0,8'd0, 3'b100,3'b010,3'b111);
    tbl[25] = mk(1,1,1,3'd0,8'd7, 3'b000,3'b000,3'b111);
    tbl[26] = mk(0,1,0,3'd0,8'd0, 3'b010,3'b010,3'b111);
    tbl[27] = mk(0,1,0,3'd0,8'd0, 3'b010,3'b000,3'b111);
    tbl[28] = mk(0,1,0,3'd0,8'd0, 3'b010,3'b010,3'b111);
    tbl[29] = mk(0,1,0,3'd0,8'd0, 3'b011,3'b001,3'b111);
    for (int k = 0; k < 30; k++) apply(tbl[k], $sformatf("tbl[%0d]", k));

    // Reload mid-count: div 10, lowered to 3 at cnt=6.
    apply(mk(1,0,0,3'd0,8'd0,  3'b000,3'b000,3'b111), "reload_rst");
    apply(mk(0,0,1,3'd0,8'd10, 3'b000,3'b000,3'b001), "reload_ld10");
    for (int k = 0; k < 6; k++) apply(mk(0,1,0,3'd0,8'd0, 3'b000,3'b000,3'b001), "reload_cnt");
    apply(mk(0,1,1,3'd0,8'd3, 3'b000,3'b000,3'b001), "reload_ld3");
    for (int k = 0; k < 2; k++) apply(mk(0,1,0,3'd0,8'd0, 3'b000,3'b000,3'b001), "reload_wait");
    apply(mk(0,1,0,3'd0,8'd0, 3'b001,3'b001,3'b001), "reload_tick1");
    for (int k = 0; k < 2; k++) apply(mk(0,1,0,3'd0,8'd0, 3'b000,3'b001,3'b001), "reload_wait2");
    apply(mk(0,1,0,3'd0,8'd0, 3'b001,3'b000,3'b001), "reload_tick2");

    // Enable stall: div 5, en low for 7 cycles at cnt=2.
    apply(mk(0,1,1,3'd0,8'd5, 3'b000,3'b000,3'b001), "stall_ld5");
    for (int k = 0; k < 2; k++) apply(mk(0,1,0,3'd0,8'd0, 3'b000,3'b000,3'b001), "stall_pre");
    for (int k = 0; k < 7; k++) apply(mk(0,0,0,3'd0,8'd0, 3'b000,3'b000,3'b001), "stall_off");
    for (int k = 0; k < 2; k++) apply(mk(0,1,0,3'd0,8'd0, 3'b000,3'b000,3'b001), "stall_post");
    apply(mk(0,1,0,3'd0,8'd0, 3'b001,3'b001,3'b001), "stall_tick");
`else
    apply(mk(1,0,0,3'd0,8'd0, 3'b000,3'b000,3'b111), "casc_rst");
    apply(mk(0,0,1,3'd0,8'd4, 3'b000,3'b000,3'b111), "casc_ld0");
    apply(mk(0,0,1,3'd1,8'd3, 3'b000,3'b000,3'b111), "casc_ld1");
    apply(mk(0,0,1,3'd2,8'd2, 3'b000,3'b000,3'b111), "casc_ld2");
    for (int n = 1; n <= 48; n++) begin
      apply(mk(0,1,0,3'd0,8'd0,
               {(n % 24) == 0, (n % 12) == 0, (n % 4) == 0},
               {1'((n / 24) % 2), 1'((n / 12) % 2), 1'((n / 4) % 2)},
               3'b111), $sformatf("casc_n%0d", n));
    end
    // A disabled head channel stalls the whole chain.
    apply(mk(0,1,1,3'd0,8'd0, 3'b000,3'b000,3'b111), "casc_ld0_zero");
    for (int k = 0; k < 20; k++) apply(mk(0,1,0,3'd0,8'd0, 3'b000,3'b000,3'b111), "casc_stall");
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_tick_gen.md
CLK_TICK_GEN -- requirements
Module: clk_tick_gen

Interface
REQ-001 SHALL have parameter NCH, default 3: number of independent divider channels, 1..8.
REQ-002 SHALL have parameter CW, default 32: divisor/counter width per channel, 2..32.
REQ-003 SHALL have parameter DIV_INIT, default {NCH{32'd50_000_000}}: NCH*CW packed reset divisors, channel i in bits [i*CW +: CW].
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  global count enable; low freezes all counters.
REQ-007 SHALL have port ld  input  1  divisor load strobe, one-cycle.
REQ-008 SHALL have port ld_ch  input  3  channel index for ld.
REQ-009 SHALL have port ld_div  input  CW  new divisor for ld.
REQ-010 SHALL have port tick  output  NCH  per-channel one-cycle pulse, registered.
REQ-011 SHALL have port sq  output  NCH  per-channel square wave, toggles on each tick, registered.

Function
REQ-012 Each channel SHALL hold registers div[i] (CW), cnt[i] (CW), tick[i], sq[i].
REQ-013 Terminal event TC[i] SHALL be: en=1, advance[i]=1, div[i]>=1, cnt[i]==div[i]-1; advance[i]=1 in non-cascade mode.
REQ-014 On an edge with TC[i]: cnt[i]<=0, tick[i]<=1, sq[i]<=~sq[i].
REQ-015 On an edge with en=1, advance[i]=1, no TC[i], div[i]>=1: cnt[i]<=cnt[i]+1, tick[i]<=0.
REQ-016 On an edge with en=0: cnt[i], sq[i] hold; tick[i]<=0.
REQ-017 div[i]==0 SHALL disable channel i: cnt[i] held 0, tick[i]=0, sq[i] held.
REQ-018 div[i]==1 SHALL produce tick[i]=1 on every enabled edge and sq[i] toggling each cycle.
REQ-019 From cnt=0 with en high, first tick[i] SHALL be high in the cycle after the div[i]-th edge, then every div[i] cycles; sq period = 2*div[i] cycles, 50% duty.
REQ-020 ld=1 with ld_ch<NCH: div[ld_ch]<=ld_div, cnt[ld_ch]<=0, tick[ld_ch]<=0, sq[ld_ch] holds; applies regardless of en.
REQ-021 ld and TC on the same channel, same edge: load SHALL win; no tick, no sq toggle.
REQ-022 ld=1 with ld_ch>=NCH SHALL be ignored; other channels SHALL be unaffected by any load.
REQ-023 Counter arithmetic SHALL be unsigned CW-bit; cnt never exceeds div-1 except transiently after a load lowering div, which REQ-020 prevents by clearing cnt.

Reset
REQ-024 rst=1 at an edge: div[i]<=DIV_INIT[i], cnt[i]<=0, tick<=0, sq<=0; rst overrides ld and en.
REQ-025 Reset mid-count SHALL discard in-progress counts; counting resumes from 0 on the first edge with rst=0.

Configuration
REQ-026 Macro CLK_TICK_GEN_CASCADE_EN defined: advance[0]=1, advance[i]=TC[i-1] for i>=1, same edge, so tick[i] coincides with a tick[i-1] cycle (e.g. ms then s chain).
REQ-027 Macro CLK_TICK_GEN_CASCADE_EN undefined: all channels count clk independently; advance[i]=1.
REQ-028 In cascade mode div[i-1]==0 SHALL stall channel i and above.

Verification (NCH=3, CW=8)
REQ-029 DIV_INIT={4,1,0}, rst 2 cycles then en=1 -> tick[0] first high in cycle after 4th edge, period 4; sq[0] period 8; tick[1] high every cycle; tick[2], sq[2] stay 0.
REQ-030 div[0]=10, en=1, at cnt[0]=6 pulse ld ld_ch=0 ld_div=3 -> no tick that edge, next tick[0] 3 cycles after load, sq[0] unchanged by load.
REQ-031 div[0]=5, en low 7 cycles at cnt[0]=2 -> no ticks during stall, tick[0] 3 edges after en returns.
REQ-032 ld ld_ch=5 ld_div=9 -> div[] unchanged, tick phases unchanged; ld coinciding with TC on channel 1 -> no tick[1].
REQ-033 Cascade build, div={4,3,2} -> tick[1] every 12 cycles aligned with tick[0]; tick[2] every 24 aligned with tick[1].
REQ-034 rst pulsed mid-count with ld asserted same edge -> divisors return to DIV_INIT, all outputs 0, load discarded.
